// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle MIPS datapath and its main control unit.
// The master is the datapath side; the slave is the controller.
interface mc_control_fsm_if;
  logic [5:0] Op;
  logic [5:0] funct;
  logic       Zero;
  logic [1:0] ALUOp;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic       PCwen;

  modport master (
    output Op, funct, Zero,
    input  ALUOp, ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg,
    input  PCWrite, PCWriteCond, RegWrite, MemWrite, MemRead, IRWrite, PCwen
  );

  modport slave (
    input  Op, funct, Zero,
    output ALUOp, ALUSrcA, ALUSrcB, PCSource, RegDst, MemtoReg,
    output PCWrite, PCWriteCond, RegWrite, MemWrite, MemRead, IRWrite, PCwen
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences fetch/decode/execute/memory/writeback,
// flags illegal opcodes and keeps cycle and retired-instruction counters.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  mc_control_fsm_if.slave  bus,
  output logic             trap,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    JAL       = 4'd10,
    I_EXEC    = 4'd11,
    I_WB      = 4'd12,
    ILLEGAL   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_e           state_q, state_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             retire;

  logic [1:0] alu_op, alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg;
  logic       pc_write, pc_write_cond, reg_write, mem_write, mem_read, ir_write;
  logic       is_bne, pc_wen;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FETCH;
      trap_q      <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      trap_q      <= trap_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (bus.Op)
          OP_RTYPE:                                   state_d = R_EXEC;
          OP_LW, OP_SW:                               state_d = MEM_ADDR;
          OP_BEQ, OP_BNE:                             state_d = BRANCH;
          OP_J:                                       state_d = JUMP;
          OP_JAL:                                     state_d = JAL;
          6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, OP_LUI:  state_d = I_EXEC;
          default:                                    state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: state_d = (bus.Op == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ: state_d = MEM_WB;
      R_EXEC:   state_d = R_WB;
      I_EXEC:   state_d = I_WB;
      MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP, JAL, I_WB: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
      default:  state_d = ILLEGAL;
    endcase
  end

  // Trap latches on the edge that enters ILLEGAL and holds until reset.
  always_comb begin
    trap_d      = trap_q | (state_d == ILLEGAL);
    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = instr_cnt_q + (retire ? CNT_W'(1) : '0);
  end

  always_comb begin
    alu_op        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    ir_write      = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      DECODE:    alu_src_b = 2'b11;
      MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      MEM_READ:  mem_read = 1'b1;
      MEM_WB: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
      end
      MEM_WRITE: mem_write = 1'b1;
      R_EXEC: begin
        alu_op    = 2'b10;
        alu_src_a = (bus.funct inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
      end
      R_WB: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
      end
      // ALU forms PC+4 of the already-incremented PC, giving fetch PC + 8 for r31.
      JAL: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        alu_src_b  = 2'b01;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        reg_write  = 1'b1;
      end
      I_EXEC: begin
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        alu_src_a = (bus.Op == OP_LUI) ? 2'b11 : 2'b01;
      end
      I_WB:      reg_write = 1'b1;
      default: ;
    endcase
  end

  assign is_bne = (bus.Op == OP_BNE);
  assign pc_wen = pc_write | (pc_write_cond & (bus.Zero ^ is_bne));

  // Gating with rst kills every write the instant reset falls, without waiting for clk.
  assign bus.ALUOp       = rst ? alu_op        : 2'b00;
  assign bus.ALUSrcA     = rst ? alu_src_a     : 2'b00;
  assign bus.ALUSrcB     = rst ? alu_src_b     : 2'b00;
  assign bus.PCSource    = rst ? pc_source     : 2'b00;
  assign bus.RegDst      = rst ? reg_dst       : 2'b00;
  assign bus.MemtoReg    = rst ? mem_to_reg    : 2'b00;
  assign bus.PCWrite     = rst & pc_write;
  assign bus.PCWriteCond = rst & pc_write_cond;
  assign bus.RegWrite    = rst & reg_write;
  assign bus.MemWrite    = rst & mem_write;
  assign bus.MemRead     = rst & mem_read;
  assign bus.IRWrite     = rst & ir_write;
  assign bus.PCwen       = rst & pc_wen;

  assign trap      = trap_q;
  assign state_o   = state_q;
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

endmodule
